// File: rtl/uart_pkg.sv
// Shared UART definitions: default baud divider, receiver state encoding,
// and the parity helper that the transmit side uses as well.
package uart_pkg;

    // 50 MHz system clock, 115200 baud.
    localparam int unsigned BR_DEFAULT = 434;

    // Receiver state encoding, kept as plain constants so that older blocks
    // which compare raw state codes remain compatible.
    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_START     = 3'd1;
    localparam logic [2:0] ST_DATA      = 3'd2;
    localparam logic [2:0] ST_PARITY    = 3'd3;
    localparam logic [2:0] ST_STOP      = 3'd4;
    localparam logic [2:0] ST_WAIT_HIGH = 3'd5;

    // Parity bit for a data word. Narrower words are zero-extended by the
    // caller, which leaves the XOR reduction unchanged.
    function automatic logic parity_calc(input logic [31:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for an asynchronous level input. It resets to 1, so
// an idle-high line does not look like an edge when reset is released.
module uart_sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    logic ff1_q;

    // Capture the async input, then re-register it to settle metastability.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: every flop is written with <= so all registers update from
        // pre-edge values; a blocking '=' here would collapse the two stages.
        if (!rst_n) begin
            ff1_q <= 1'b1;
            q_o   <= 1'b1;
        end else begin
            ff1_q <= d_i;
            q_o   <= ff1_q;
        end
    end

endmodule

// File: rtl/uart_rx_byte.sv
// UART receiver: recovers one framed word (start, data LSB first, optional
// parity, stop) from rx and holds it in a valid/ready output register.
// Framing errors, parity errors and overruns are reported as 1-cycle pulses.
module uart_rx_byte
    import uart_pkg::*;
#(
    parameter int BR         = BR_DEFAULT,
    parameter int DATA_WIDTH = 8,
    parameter int PARITY_EN  = 1,
    parameter int PARITY_ODD = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  rx,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_vld,
    input  logic                  rd_rdy,
    output logic                  parity_err,
    output logic                  frame_err,
    output logic                  overrun,
    output logic                  busy
);

    localparam int CW = $clog2(BR);
    localparam int IW = $clog2(DATA_WIDTH);

    // Sample points: the start bit is checked at its centre; every later bit
    // is sampled one full bit period after the previous sample.
    localparam logic [CW-1:0] HALF_M1  = CW'(BR / 2 - 1);
    localparam logic [CW-1:0] BIT_M1   = CW'(BR - 1);
    localparam logic [IW-1:0] LAST_BIT = IW'(DATA_WIDTH - 1);
    localparam logic          ODD      = (PARITY_ODD != 0);

    logic                  rxs;
    logic                  rxs_prev_q;
    logic [2:0]            state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [IW-1:0]         bit_idx_q, bit_idx_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic                  par_bad_q, par_bad_d;
    logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
    logic                  rd_vld_q, rd_vld_d;
    logic                  parity_err_q, parity_err_d;
    logic                  frame_err_q, frame_err_d;
    logic                  overrun_q, overrun_d;

    uart_sync2 u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (rx),
        .q_o   (rxs)
    );

    // Next-state logic for the frame FSM and the holding register.
    always_comb begin
        // NOTE: every signal gets a default before the case statement, so no
        // path leaves one unassigned and no latch is inferred.
        state_d      = state_q;
        cnt_d        = cnt_q;
        bit_idx_d    = bit_idx_q;
        shift_d      = shift_q;
        par_bad_d    = par_bad_q;
        rd_data_d    = rd_data_q;
        rd_vld_d     = rd_vld_q;
        parity_err_d = 1'b0;
        frame_err_d  = 1'b0;
        overrun_d    = 1'b0;

        // A consumer handshake empties the register unless a new word reloads it below.
        if (rd_vld_q && rd_rdy) rd_vld_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (rxs_prev_q && !rxs) begin
                    state_d   = ST_START;
                    cnt_d     = '0;
                    par_bad_d = 1'b0;
                end
            end
            ST_START: begin
                if (cnt_q == HALF_M1) begin
                    if (rxs) begin
                        state_d = ST_IDLE;          // glitch, not a real start bit
                    end else begin
                        state_d   = ST_DATA;
                        cnt_d     = '0;
                        bit_idx_d = '0;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_DATA: begin
                if (cnt_q == BIT_M1) begin
                    cnt_d              = '0;
                    shift_d[bit_idx_q] = rxs;
                    if (bit_idx_q == LAST_BIT) begin
                        state_d = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + IW'(1);
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_PARITY: begin
                if (cnt_q == BIT_M1) begin
                    cnt_d     = '0;
                    par_bad_d = (rxs != parity_calc(32'(shift_q), ODD));
                    state_d   = ST_STOP;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_STOP: begin
                if (cnt_q == BIT_M1) begin
                    cnt_d = '0;
                    if (!rxs) begin
                        frame_err_d = 1'b1;
                        state_d     = ST_WAIT_HIGH;
                    end else if (par_bad_q) begin
                        parity_err_d = 1'b1;
                        state_d      = ST_IDLE;
                    end else begin
                        state_d = ST_IDLE;
                        if (!rd_vld_q || rd_rdy) begin
                            rd_data_d = shift_q;
                            rd_vld_d  = 1'b1;
                        end else begin
                            overrun_d = 1'b1;
                        end
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_WAIT_HIGH: begin
                // Line held low (break): wait for it to return to idle.
                if (rxs) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and output registers; reset aborts any frame in progress.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rxs_prev_q   <= 1'b1;
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            bit_idx_q    <= '0;
            shift_q      <= '0;
            par_bad_q    <= 1'b0;
            rd_data_q    <= '0;
            rd_vld_q     <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            rxs_prev_q   <= rxs;
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            bit_idx_q    <= bit_idx_d;
            shift_q      <= shift_d;
            par_bad_q    <= par_bad_d;
            rd_data_q    <= rd_data_d;
            rd_vld_q     <= rd_vld_d;
            parity_err_q <= parity_err_d;
            frame_err_q  <= frame_err_d;
            overrun_q    <= overrun_d;
        end
    end

    assign rd_data    = rd_data_q;
    assign rd_vld     = rd_vld_q;
    assign parity_err = parity_err_q;
    assign frame_err  = frame_err_q;
    assign overrun    = overrun_q;
    assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_byte.sv
// Directed testbench for uart_rx_byte at BR=16, 8 data bits, even parity.
module tb_uart_rx_byte;

    localparam int BR = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx = 1'b1;
    logic       rd_rdy = 1'b0;
    logic [7:0] rd_data;
    logic       rd_vld;
    logic       parity_err;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    int tests  = 0;
    int errors = 0;

    // Cycle counts of each pulse output, sampled on the falling edge.
    int par_cnt = 0;
    int frm_cnt = 0;
    int ovr_cnt = 0;

    uart_rx_byte #(
        .BR         (BR),
        .DATA_WIDTH (8),
        .PARITY_EN  (1),
        .PARITY_ODD (0)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx         (rx),
        .rd_data    (rd_data),
        .rd_vld     (rd_vld),
        .rd_rdy     (rd_rdy),
        .parity_err (parity_err),
        .frame_err  (frame_err),
        .overrun    (overrun),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (parity_err) par_cnt++;
        if (frame_err)  frm_cnt++;
        if (overrun)    ovr_cnt++;
    end

    // Advance n rising edges and settle 1 time unit past the last one.
    task automatic wait_cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive_bit(input logic b);
        rx = b;
        wait_cycles(BR);
    endtask

    // Start, 8 data bits LSB first, even parity (optionally flipped), then
    // stop_low bit times of low line followed by one high stop/idle bit.
    task automatic send_frame(input logic [7:0] data, input logic par_flip, input int stop_low);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(data[i]);
        drive_bit((^data) ^ par_flip);
        for (int i = 0; i < stop_low; i++) drive_bit(1'b0);
        drive_bit(1'b1);
    endtask

    task automatic drain();
        rd_rdy = 1'b1;
        wait_cycles(1);
        rd_rdy = 1'b0;
        tests++;
        if (rd_vld !== 1'b0) begin
            errors++;
            $display("FAIL drain_vld: got %b expected 0", rd_vld);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        rx    = 1'b1;
        wait_cycles(3);
        tests++;
        if ({rd_data, rd_vld, parity_err, frame_err, overrun, busy} !== 13'h0) begin
            errors++;
            $display("FAIL reset_outputs: got data=%h vld=%b pe=%b fe=%b ov=%b busy=%b expected all 0",
                     rd_data, rd_vld, parity_err, frame_err, overrun, busy);
        end
        rst_n = 1'b1;
        wait_cycles(4);
        tests++;
        if (busy !== 1'b0 || rd_vld !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: got busy=%b vld=%b expected 0 0", busy, rd_vld);
        end
    endtask

    // 0xA5: rd_vld must first be seen 2 + 8 + 160 + 1 edges after the pin falls.
    task automatic test_latency();
        int  n;
        bit  got;
        int  p0, f0, o0;
        p0 = par_cnt; f0 = frm_cnt; o0 = ovr_cnt;
        n = 0; got = 1'b0;
        fork
            send_frame(8'hA5, 1'b0, 0);
            begin
                while (n < 400 && !got) begin
                    @(posedge clk);
                    #1;
                    n++;
                    if (rd_vld) got = 1'b1;
                end
            end
        join
        tests++;
        if (!got || n != 171) begin
            errors++;
            $display("FAIL latency: got %0d cycles (seen=%0b) expected 171", n, got);
        end
        tests++;
        if (rd_data !== 8'hA5) begin
            errors++;
            $display("FAIL latency_data: got %h expected a5", rd_data);
        end
        tests++;
        if (par_cnt != p0 || frm_cnt != f0 || ovr_cnt != o0) begin
            errors++;
            $display("FAIL latency_flags: got pe=%0d fe=%0d ov=%0d expected no new pulses",
                     par_cnt - p0, frm_cnt - f0, ovr_cnt - o0);
        end
        drain();
    endtask

    task automatic test_parity();
        int p0;
        p0 = par_cnt;
        send_frame(8'h3C, 1'b1, 0);
        wait_cycles(4);
        tests++;
        if (par_cnt != p0 + 1) begin
            errors++;
            $display("FAIL parity_pulse: got %0d pulse cycles expected 1", par_cnt - p0);
        end
        tests++;
        if (rd_vld !== 1'b0) begin
            errors++;
            $display("FAIL parity_drop: got vld=%b expected 0", rd_vld);
        end
    endtask

    // 0x00 with the stop region held low for 3 bit times (13 low bit times in all).
    task automatic test_frame_break();
        int f0;
        f0 = frm_cnt;
        fork
            send_frame(8'h00, 1'b0, 3);
            begin
                wait_cycles(200);
                tests++;
                if (busy !== 1'b1 || frm_cnt != f0 + 1) begin
                    errors++;
                    $display("FAIL break_wait: got busy=%b fe=%0d expected busy=1 fe=1",
                             busy, frm_cnt - f0);
                end
            end
        join
        tests++;
        if (busy !== 1'b0 || rd_vld !== 1'b0) begin
            errors++;
            $display("FAIL break_exit: got busy=%b vld=%b expected 0 0", busy, rd_vld);
        end
        send_frame(8'h81, 1'b0, 0);
        tests++;
        if (rd_vld !== 1'b1 || rd_data !== 8'h81 || frm_cnt != f0 + 1) begin
            errors++;
            $display("FAIL break_next: got vld=%b data=%h fe=%0d expected 1 81 1",
                     rd_vld, rd_data, frm_cnt - f0);
        end
        drain();
    endtask

    // 4-cycle low pulse: START checks at T0+8, so busy spans edges 3..10 after the pin falls.
    task automatic test_glitch();
        int p0, f0, o0;
        p0 = par_cnt; f0 = frm_cnt; o0 = ovr_cnt;
        rx = 1'b0;
        wait_cycles(4);
        rx = 1'b1;
        wait_cycles(6);
        tests++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL glitch_busy: got %b expected 1", busy);
        end
        wait_cycles(1);
        tests++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL glitch_idle: got %b expected 0", busy);
        end
        wait_cycles(40);
        tests++;
        if (rd_vld !== 1'b0 || par_cnt != p0 || frm_cnt != f0 || ovr_cnt != o0) begin
            errors++;
            $display("FAIL glitch_quiet: got vld=%b pe=%0d fe=%0d ov=%0d expected all 0",
                     rd_vld, par_cnt - p0, frm_cnt - f0, ovr_cnt - o0);
        end
    endtask

    task automatic test_back_to_back();
        int o0;
        o0 = ovr_cnt;
        rd_rdy = 1'b0;
        send_frame(8'h11, 1'b0, 0);
        send_frame(8'h22, 1'b0, 0);
        tests++;
        if (rd_vld !== 1'b1 || rd_data !== 8'h11) begin
            errors++;
            $display("FAIL b2b_hold: got vld=%b data=%h expected 1 11", rd_vld, rd_data);
        end
        tests++;
        if (ovr_cnt != o0 + 1) begin
            errors++;
            $display("FAIL b2b_overrun: got %0d pulse cycles expected 1", ovr_cnt - o0);
        end
        drain();
        o0 = ovr_cnt;
        send_frame(8'h11, 1'b0, 0);
        // rd_rdy covers only the stop-sample cycle of 0x22 (edges 170..171).
        fork
            send_frame(8'h22, 1'b0, 0);
            begin
                wait_cycles(170);
                rd_rdy = 1'b1;
                wait_cycles(1);
                rd_rdy = 1'b0;
            end
        join
        tests++;
        if (rd_vld !== 1'b1 || rd_data !== 8'h22) begin
            errors++;
            $display("FAIL b2b_swap: got vld=%b data=%h expected 1 22", rd_vld, rd_data);
        end
        tests++;
        if (ovr_cnt != o0) begin
            errors++;
            $display("FAIL b2b_no_overrun: got %0d pulse cycles expected 0", ovr_cnt - o0);
        end
    endtask

    // Reset in the middle of data bit 4 of a 0xF0 frame; 0x22 is still held beforehand.
    task automatic test_mid_reset();
        logic [7:0] d;
        d = 8'hF0;
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(d[i]);
        rx = d[4];
        wait_cycles(8);
        rst_n = 1'b0;
        rx    = 1'b1;
        #1;
        tests++;
        if ({rd_data, rd_vld, parity_err, frame_err, overrun, busy} !== 13'h0) begin
            errors++;
            $display("FAIL midrst_outputs: got data=%h vld=%b pe=%b fe=%b ov=%b busy=%b expected all 0",
                     rd_data, rd_vld, parity_err, frame_err, overrun, busy);
        end
        wait_cycles(3);
        rst_n = 1'b1;
        wait_cycles(200);
        tests++;
        if (busy !== 1'b0 || rd_vld !== 1'b0) begin
            errors++;
            $display("FAIL midrst_idle: got busy=%b vld=%b expected 0 0", busy, rd_vld);
        end
        send_frame(8'h5A, 1'b0, 0);
        tests++;
        if (rd_vld !== 1'b1 || rd_data !== 8'h5A) begin
            errors++;
            $display("FAIL midrst_frame: got vld=%b data=%h expected 1 5a", rd_vld, rd_data);
        end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_parity();
        test_frame_break();
        test_glitch();
        test_back_to_back();
        test_mid_reset();
        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
